// File: rtl/serial_adder_seq.sv
// Bit-serial unsigned adder: accepts A/B over a valid/ready handshake,
// adds one bit per clock (LSB first) through two cascaded half adders with
// a registered carry, and returns {C,S} over a second valid/ready handshake.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic             c_reg, c_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             in_ready_reg, in_ready_next;
  logic             out_valid_reg, out_valid_next;

  // Bit slice: first half adder combines the operand bits, second folds in the carry.
  logic ha1_s, ha1_c, ha2_s, ha2_c;
  logic bit_sum, bit_carry;

  assign ha1_s     = a_reg[0] ^ b_reg[0];
  assign ha1_c     = a_reg[0] & b_reg[0];
  assign ha2_s     = ha1_s ^ carry_reg;
  assign ha2_c     = ha1_s & carry_reg;
  assign bit_sum   = ha2_s;
  assign bit_carry = ha1_c | ha2_c;

  // State and datapath registers; async reset aborts any in-flight addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      s_reg         <= '0;
      c_reg         <= 1'b0;
      carry_reg     <= 1'b0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      sum_reg       <= sum_next;
      s_reg         <= s_next;
      c_reg         <= c_next;
      carry_reg     <= carry_next;
      count_reg     <= count_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    sum_next       = sum_reg;
    s_next         = s_reg;
    c_next         = c_reg;
    carry_next     = carry_reg;
    count_next     = count_reg;
    in_ready_next  = in_ready_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready_reg) begin
          a_next        = A;
          b_next        = B;
          carry_next    = 1'b0;
          count_next    = '0;
          in_ready_next = 1'b0;
          state_next    = SHIFT;
        end else begin
          // Also raises in_ready on the first edge after reset release.
          in_ready_next = 1'b1;
        end
      end

      SHIFT: begin
        sum_next   = {bit_sum, sum_reg[WIDTH-1:1]};
        a_next     = {1'b0, a_reg[WIDTH-1:1]};
        b_next     = {1'b0, b_reg[WIDTH-1:1]};
        carry_next = bit_carry;
        if (count_reg == LAST) begin
          // Last bit: publish the result directly from this edge's sum.
          s_next         = {bit_sum, sum_reg[WIDTH-1:1]};
          c_next         = bit_carry;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign S         = s_reg;
  assign C         = c_reg;
  assign busy      = (state_reg != IDLE);

endmodule
